// File: rtl/ct_had_ddc_ctrl_pkg.sv
// HAD direct-download sequencer: shared types and defaults.
// State encoding and watchdog width used by the DDC control slice.
package ct_had_ddc_ctrl_pkg;

    localparam int DDC_TO_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_AREQ  = 3'd1,
        ST_AWAIT = 3'd2,
        ST_DREQ  = 3'd3,
        ST_DWAIT = 3'd4,
        ST_SREQ  = 3'd5,
        ST_SWAIT = 3'd6,
        ST_AINC  = 3'd7
    } ddc_state_e;

    function automatic logic ddc_is_req(input ddc_state_e s);
        return (s == ST_AREQ) || (s == ST_DREQ) || (s == ST_SREQ);
    endfunction

    function automatic logic ddc_is_wait(input ddc_state_e s);
        return (s == ST_AWAIT) || (s == ST_DWAIT) || (s == ST_SWAIT);
    endfunction

endpackage

// File: rtl/ct_had_ddc_ctrl_if.sv
// HAD DDC control bundle: JTAG strobes, inject handshake, RTU status,
// datapath selects and register-file status.
interface ct_had_ddc_ctrl_if;

    logic regs_ddc_en;
    logic x_sm_xx_update_dr_en;
    logic ir_xx_ddata_reg_sel;
    logic ir_xx_daddr_reg_sel;
    logic ctrl_ddc_exec_rdy;
    logic rtu_had_inst_cmplt;
    logic rtu_had_inst_expt;
    logic ddc_ctrl_exec_req;
    logic ddc_ctrl_dp_addr_sel;
    logic ddc_ctrl_dp_data_sel;
    logic ddc_ctrl_dp_addr_gen;
    logic ddc_regs_busy;
    logic ddc_regs_err;
    logic ddc_regs_overrun;

    modport master (
        input  regs_ddc_en,
        input  x_sm_xx_update_dr_en,
        input  ir_xx_ddata_reg_sel,
        input  ir_xx_daddr_reg_sel,
        input  ctrl_ddc_exec_rdy,
        input  rtu_had_inst_cmplt,
        input  rtu_had_inst_expt,
        output ddc_ctrl_exec_req,
        output ddc_ctrl_dp_addr_sel,
        output ddc_ctrl_dp_data_sel,
        output ddc_ctrl_dp_addr_gen,
        output ddc_regs_busy,
        output ddc_regs_err,
        output ddc_regs_overrun
    );

    modport slave (
        output regs_ddc_en,
        output x_sm_xx_update_dr_en,
        output ir_xx_ddata_reg_sel,
        output ir_xx_daddr_reg_sel,
        output ctrl_ddc_exec_rdy,
        output rtu_had_inst_cmplt,
        output rtu_had_inst_expt,
        input  ddc_ctrl_exec_req,
        input  ddc_ctrl_dp_addr_sel,
        input  ddc_ctrl_dp_data_sel,
        input  ddc_ctrl_dp_addr_gen,
        input  ddc_regs_busy,
        input  ddc_regs_err,
        input  ddc_regs_overrun
    );

endinterface

// File: rtl/ct_had_ddc_wdog.sv
// Per-instruction completion watchdog for the DDC sequencer.
// Saturating counter; expire holds while the count is at its maximum.
module ct_had_ddc_wdog #(
    parameter int TO_W = 10
) (
    input  logic cpuclk,
    input  logic cpurst,
    input  logic clr,
    input  logic cnt,
    output logic expire
);

    logic [TO_W-1:0] count;

    assign expire = &count;

    // count wait cycles, restart on each new issue, stick at the top
    always_ff @(posedge cpuclk or posedge cpurst) begin
        if (cpurst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (cnt && !expire) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ct_had_ddc_ctrl.sv
// HAD direct-download sequencer: mv x1, mv x2, sd x2,0(x1), DADDR += 8.
// Owns the FSM, the address-valid shortcut and the sticky status flags.
module ct_had_ddc_ctrl
    import ct_had_ddc_ctrl_pkg::*;
#(
    parameter int TO_W = DDC_TO_W
) (
    input  logic               cpuclk,
    input  logic               cpurst,
    ct_had_ddc_ctrl_if.master  ddc
);

    ddc_state_e state;
    ddc_state_e state_nxt;
    logic       addr_vld;
    logic       err;
    logic       ovr;
    logic       busy;
    logic       trig;
    logic       aw;
    logic       in_wait;
    logic       xfer;
    logic       done;
    logic       fail;
    logic       expire;

    assign trig    = ddc.x_sm_xx_update_dr_en & ddc.ir_xx_ddata_reg_sel;
    assign aw      = ddc.x_sm_xx_update_dr_en & ddc.ir_xx_daddr_reg_sel;
    assign busy    = (state != ST_IDLE);
    assign in_wait = ddc_is_wait(state);
    assign xfer    = ddc_is_req(state) & ddc.ctrl_ddc_exec_rdy;
    assign done    = in_wait & ddc.rtu_had_inst_cmplt & ~ddc.rtu_had_inst_expt;
    assign fail    = in_wait & ((ddc.rtu_had_inst_cmplt & ddc.rtu_had_inst_expt)
                              | (~ddc.rtu_had_inst_cmplt & expire));

    ct_had_ddc_wdog #(
        .TO_W   (TO_W)
    ) u_wdog (
        .cpuclk (cpuclk),
        .cpurst (cpurst),
        .clr    (xfer),
        .cnt    (in_wait),
        .expire (expire)
    );

    // state register
    always_ff @(posedge cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state: start on trig, step on retire, abort on error
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (trig && !aw && ddc.regs_ddc_en) begin
                    state_nxt = addr_vld ? ST_DREQ : ST_AREQ;
                end
            end
            ST_AREQ:  if (ddc.ctrl_ddc_exec_rdy) state_nxt = ST_AWAIT;
            ST_DREQ:  if (ddc.ctrl_ddc_exec_rdy) state_nxt = ST_DWAIT;
            ST_SREQ:  if (ddc.ctrl_ddc_exec_rdy) state_nxt = ST_SWAIT;
            ST_AWAIT: begin
                if (done)      state_nxt = ST_DREQ;
                else if (fail) state_nxt = ST_IDLE;
            end
            ST_DWAIT: begin
                if (done)      state_nxt = ST_SREQ;
                else if (fail) state_nxt = ST_IDLE;
            end
            ST_SWAIT: begin
                if (done)      state_nxt = ST_AINC;
                else if (fail) state_nxt = ST_IDLE;
            end
            ST_AINC:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // address-valid shortcut and sticky err/overrun flags
    always_ff @(posedge cpuclk or posedge cpurst) begin
        if (cpurst) begin
            addr_vld <= 1'b0;
            err      <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            if (busy) begin
                if (trig || aw) ovr <= 1'b1;
            end else if (aw) begin
                err <= 1'b0;
                ovr <= 1'b0;
            end
            if (fail) err <= 1'b1;
            if (!busy && (aw || !ddc.regs_ddc_en)) begin
                addr_vld <= 1'b0;
            end else if (fail) begin
                addr_vld <= 1'b0;
            end else if (state == ST_AWAIT && done) begin
                addr_vld <= 1'b1;
            end
        end
    end

    assign ddc.ddc_ctrl_exec_req    = ddc_is_req(state);
    assign ddc.ddc_ctrl_dp_addr_sel = (state == ST_AREQ) | (state == ST_AWAIT);
    assign ddc.ddc_ctrl_dp_data_sel = (state == ST_DREQ) | (state == ST_DWAIT);
    assign ddc.ddc_ctrl_dp_addr_gen = (state == ST_AINC);
    assign ddc.ddc_regs_busy        = busy;
    assign ddc.ddc_regs_err         = err;
    assign ddc.ddc_regs_overrun     = ovr;

endmodule

// File: tb/tb_ct_had_ddc_ctrl.sv
// Bench for the HAD DDC sequencer: instruction-queue reference model,
// per-cycle output compare, directed scenarios and random traffic.
module tb_ct_had_ddc_ctrl;

    localparam int TO_W   = 10;
    localparam int WD_MAX = (1 << TO_W) - 1;
    localparam int K_A = 0;
    localparam int K_D = 1;
    localparam int K_S = 2;
    localparam int K_I = 3;

    logic cpuclk = 1'b0;
    logic cpurst;

    ct_had_ddc_ctrl_if ifc();

    ct_had_ddc_ctrl #(
        .TO_W   (TO_W)
    ) dut (
        .cpuclk (cpuclk),
        .cpurst (cpurst),
        .ddc    (ifc)
    );

    always #5 cpuclk = ~cpuclk;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 30)
                $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // reference model: pending instruction list of the current download
    int mq[$];
    bit m_infl;
    int m_wc;
    bit m_avld;
    bit m_err;
    bit m_ovr;

    task automatic model_step();
        bit trig;
        bit aw;
        trig = ifc.x_sm_xx_update_dr_en && ifc.ir_xx_ddata_reg_sel;
        aw   = ifc.x_sm_xx_update_dr_en && ifc.ir_xx_daddr_reg_sel;
        if (mq.size() == 0) begin
            if (aw) begin
                m_err = 0;
                m_ovr = 0;
                m_avld = 0;
            end else if (!ifc.regs_ddc_en) begin
                m_avld = 0;
            end
            if (trig && !aw && ifc.regs_ddc_en) begin
                if (!m_avld) mq.push_back(K_A);
                mq.push_back(K_D);
                mq.push_back(K_S);
                mq.push_back(K_I);
                m_infl = 0;
            end
        end else begin
            if (trig || aw) m_ovr = 1;
            if (mq[0] == K_I) begin
                void'(mq.pop_front());
            end else if (!m_infl) begin
                if (ifc.ctrl_ddc_exec_rdy) begin
                    m_infl = 1;
                    m_wc = 0;
                end
            end else if (ifc.rtu_had_inst_cmplt && !ifc.rtu_had_inst_expt) begin
                if (mq[0] == K_A) m_avld = 1;
                void'(mq.pop_front());
                m_infl = 0;
            end else if (ifc.rtu_had_inst_cmplt || m_wc == WD_MAX) begin
                m_err = 1;
                m_avld = 0;
                mq.delete();
                m_infl = 0;
            end else begin
                m_wc++;
            end
        end
    endtask

    always @(posedge cpuclk or posedge cpurst) begin
        if (cpurst) begin
            mq.delete();
            m_infl = 0;
            m_wc = 0;
            m_avld = 0;
            m_err = 0;
            m_ovr = 0;
        end else begin
            model_step();
        end
    end

    // per-cycle compare plus observation counters
    int n_xfer = 0;
    int n_agen = 0;
    int n_asel = 0;
    int n_sreq = 0;
    logic e_busy, e_req, e_asel, e_dsel, e_agen;

    always @(negedge cpuclk) begin
        if (!cpurst) begin
            e_busy = (mq.size() != 0);
            e_req  = e_busy && !m_infl && mq[0] != K_I;
            e_asel = e_busy && mq[0] == K_A;
            e_dsel = e_busy && mq[0] == K_D;
            e_agen = e_busy && mq[0] == K_I;
            check("exec_req", ifc.ddc_ctrl_exec_req, e_req);
            check("addr_sel", ifc.ddc_ctrl_dp_addr_sel, e_asel);
            check("data_sel", ifc.ddc_ctrl_dp_data_sel, e_dsel);
            check("addr_gen", ifc.ddc_ctrl_dp_addr_gen, e_agen);
            check("busy", ifc.ddc_regs_busy, e_busy);
            check("err", ifc.ddc_regs_err, m_err);
            check("overrun", ifc.ddc_regs_overrun, m_ovr);
            n_xfer += int'(ifc.ddc_ctrl_exec_req && ifc.ctrl_ddc_exec_rdy);
            n_agen += int'(ifc.ddc_ctrl_dp_addr_gen);
            n_asel += int'(ifc.ddc_ctrl_dp_addr_sel);
            n_sreq += int'(ifc.ddc_ctrl_exec_req && !ifc.ddc_ctrl_dp_addr_sel
                           && !ifc.ddc_ctrl_dp_data_sel);
        end
    end

    // RTU responder: 1 = retire one cycle after transfer, 2 = random
    int rsp_mode = 1;
    bit expt_data = 0;
    bit pend = 0;
    bit pend_d = 0;
    bit rc;

    always @(negedge cpuclk) begin
        case (rsp_mode)
            1: begin
                ifc.rtu_had_inst_cmplt = pend;
                ifc.rtu_had_inst_expt  = pend && pend_d && expt_data;
            end
            2: begin
                rc = ($urandom_range(2) == 0);
                ifc.rtu_had_inst_cmplt = rc;
                ifc.rtu_had_inst_expt  = rc && ($urandom_range(7) == 0);
            end
            default: begin
                ifc.rtu_had_inst_cmplt = 1'b0;
                ifc.rtu_had_inst_expt  = 1'b0;
            end
        endcase
        pend   = ifc.ddc_ctrl_exec_req && ifc.ctrl_ddc_exec_rdy;
        pend_d = ifc.ddc_ctrl_dp_data_sel;
    end

    function automatic logic [6:0] outs();
        return {ifc.ddc_ctrl_exec_req, ifc.ddc_ctrl_dp_addr_sel,
                ifc.ddc_ctrl_dp_data_sel, ifc.ddc_ctrl_dp_addr_gen,
                ifc.ddc_regs_busy, ifc.ddc_regs_err, ifc.ddc_regs_overrun};
    endfunction

    task automatic cyc();
        @(posedge cpuclk);
        #2;
    endtask

    task automatic pulse_aw();
        ifc.x_sm_xx_update_dr_en = 1'b1;
        ifc.ir_xx_daddr_reg_sel  = 1'b1;
        cyc();
        ifc.x_sm_xx_update_dr_en = 1'b0;
        ifc.ir_xx_daddr_reg_sel  = 1'b0;
    endtask

    // DDATA write; optional second write and reset at given cycles
    task automatic run_seq(input int trig2_at, input int rst_at,
                           output int lat);
        ifc.x_sm_xx_update_dr_en = 1'b1;
        ifc.ir_xx_ddata_reg_sel  = 1'b1;
        lat = 0;
        do begin
            cyc();
            lat++;
            ifc.x_sm_xx_update_dr_en = (lat == trig2_at);
            ifc.ir_xx_ddata_reg_sel  = (lat == trig2_at);
            if (lat == rst_at) begin
                check("t6_pre_ovr", ifc.ddc_regs_overrun, 1);
                check("t6_pre_dsel", ifc.ddc_ctrl_dp_data_sel, 1);
                cpurst = 1'b1;
                #1;
                check("t6_rst_outs", outs(), 0);
                #1;
                cpurst = 1'b0;
            end
        end while (ifc.ddc_regs_busy && lat < 2000);
        check("seq_bound", ifc.ddc_regs_busy, 0);
        ifc.x_sm_xx_update_dr_en = 1'b0;
        ifc.ir_xx_ddata_reg_sel  = 1'b0;
    endtask

    int lat;
    int x0, a0, s0, g0, n;
    int r;

    initial begin
        cpurst = 1'b1;
        ifc.regs_ddc_en          = 1'b0;
        ifc.x_sm_xx_update_dr_en = 1'b0;
        ifc.ir_xx_ddata_reg_sel  = 1'b0;
        ifc.ir_xx_daddr_reg_sel  = 1'b0;
        ifc.ctrl_ddc_exec_rdy    = 1'b0;
        repeat (3) cyc();
        check("reset_outs", outs(), 0);
        cpurst = 1'b0;
        ifc.regs_ddc_en = 1'b1;
        ifc.ctrl_ddc_exec_rdy = 1'b1;
        cyc();

        // 1) DADDR then DDATA: three instructions, one increment
        pulse_aw();
        x0 = n_xfer; g0 = n_agen; a0 = n_asel;
        run_seq(0, 0, lat);
        check("t1_lat", lat, 8);
        check("t1_xfers", n_xfer - x0, 3);
        check("t1_agen", n_agen - g0, 1);
        check("t1_asel", n_asel - a0, 2);
        check("t1_err", ifc.ddc_regs_err, 0);

        // 2) second DDATA reuses loaded address
        x0 = n_xfer; g0 = n_agen; a0 = n_asel;
        run_seq(0, 0, lat);
        check("t2_lat", lat, 6);
        check("t2_xfers", n_xfer - x0, 2);
        check("t2_agen", n_agen - g0, 1);
        check("t2_asel", n_asel - a0, 0);

        // 3) exception on the data move
        expt_data = 1;
        g0 = n_agen; s0 = n_sreq;
        run_seq(0, 0, lat);
        expt_data = 0;
        check("t3_lat", lat, 3);
        check("t3_err", ifc.ddc_regs_err, 1);
        check("t3_agen", n_agen - g0, 0);
        check("t3_sreq", n_sreq - s0, 0);
        a0 = n_asel;
        run_seq(0, 0, lat);
        check("t3_restart_lat", lat, 8);
        check("t3_restart_asel", n_asel - a0, 2);
        check("t3_err_sticky", ifc.ddc_regs_err, 1);
        pulse_aw();
        check("t3_aw_clr", ifc.ddc_regs_err, 0);

        // 4) stalled inject, then watchdog timeout
        rsp_mode = 0;
        ifc.ctrl_ddc_exec_rdy = 1'b0;
        ifc.x_sm_xx_update_dr_en = 1'b1;
        ifc.ir_xx_ddata_reg_sel  = 1'b1;
        cyc();
        ifc.x_sm_xx_update_dr_en = 1'b0;
        ifc.ir_xx_ddata_reg_sel  = 1'b0;
        repeat (50) cyc();
        check("t4_req_held", ifc.ddc_ctrl_exec_req, 1);
        check("t4_asel_held", ifc.ddc_ctrl_dp_addr_sel, 1);
        check("t4_no_err", ifc.ddc_regs_err, 0);
        ifc.ctrl_ddc_exec_rdy = 1'b1;
        n = 0;
        do begin
            cyc();
            n++;
        end while (ifc.ddc_regs_busy && n < 1200);
        check("t4_timeout_lat", n, 1025);
        check("t4_err", ifc.ddc_regs_err, 1);
        rsp_mode = 1;
        cyc();

        // 5) DDATA write while the store is outstanding
        pulse_aw();
        x0 = n_xfer; g0 = n_agen;
        run_seq(6, 0, lat);
        check("t5_lat", lat, 8);
        check("t5_ovr", ifc.ddc_regs_overrun, 1);
        check("t5_agen", n_agen - g0, 1);
        check("t5_xfers", n_xfer - x0, 3);
        pulse_aw();
        check("t5_aw_clr", ifc.ddc_regs_overrun, 0);

        // 6) reset in DWAIT, then trig with DDC disabled
        run_seq(0, 0, lat);
        run_seq(1, 2, lat);
        check("t6_rst_lat", lat, 2);
        ifc.regs_ddc_en = 1'b0;
        ifc.x_sm_xx_update_dr_en = 1'b1;
        ifc.ir_xx_ddata_reg_sel  = 1'b1;
        cyc();
        ifc.x_sm_xx_update_dr_en = 1'b0;
        ifc.ir_xx_ddata_reg_sel  = 1'b0;
        check("t6_dis_busy0", ifc.ddc_regs_busy, 0);
        cyc();
        check("t6_dis_busy1", ifc.ddc_regs_busy, 0);
        ifc.regs_ddc_en = 1'b1;

        // random traffic against the model
        rsp_mode = 2;
        for (int i = 0; i < 4000; i++) begin
            cyc();
            if (i == 2000) begin
                cpurst = 1'b1;
                #1;
                cpurst = 1'b0;
            end
            ifc.ctrl_ddc_exec_rdy = ($urandom_range(3) != 0);
            ifc.regs_ddc_en = ($urandom_range(15) != 0);
            r = $urandom_range(15);
            ifc.x_sm_xx_update_dr_en = (r <= 2);
            ifc.ir_xx_ddata_reg_sel  = (r == 0) || (r == 2);
            ifc.ir_xx_daddr_reg_sel  = (r == 1) || (r == 2 && $urandom_range(3) == 0);
        end
        ifc.x_sm_xx_update_dr_en = 1'b0;
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "time limit");
    end

endmodule
